// File: rtl/fp_mul_arbiter_if.sv
// fp_mul_arbiter_if
//   Bundles the requester, result and multiplier-side signals of
//   fp_mul_arbiter.
//   slave  : arbiter view. It consumes requests and drives results
//            and multiplier operands.
//   master : environment view. This covers the clients, the result
//            consumer and the multiplier.
// Signals:
//   req_valid/req_ready [NUM_REQ]   per-requester handshake
//   req_a/req_b [32*NUM_REQ]        packed operands, requester i at [32*i +: 32]
//   res_valid/res_ready, res_y[32], res_id[ID_W]   result port
//   mul_a/mul_b [32] out, mul_y [32] in            multiplier link
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [31:0]           res_y;
  logic [ID_W-1:0]       res_id;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_y;

  modport slave (
    input  req_valid, req_a, req_b, res_ready, mul_y,
    output req_ready, res_valid, res_y, res_id, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, res_ready, mul_y,
    input  req_ready, res_valid, res_y, res_id, mul_a, mul_b
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Shares one fp_mul datapath among NUM_REQ requesters. Grants are issued
//   round-robin. The arbiter drives registered operands to the multiplier,
//   waits MUL_LAT cycles, and then returns the product tagged with the
//   requester index.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   fp_mul_arbiter_if.slave; carries requests, results and the multiplier link
//   busy  high whenever the arbiter is not idle
// Optional build macro:
//   FP_MUL_ARB_ZERO_BYPASS_EN  when defined, an accepted operand pair with
//   either exponent field equal to zero skips the multiplier. In that case
//   a signed zero is returned one cycle after accept.
//
// state | meaning
// IDLE  | searching for a request; req_ready is the combinational grant
// RUN   | operands on mul_a/mul_b, counting down MUL_LAT
// HOLD  | result presented, waiting for res_ready
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  fp_mul_arbiter_if.slave bus,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [3:0]      LAT_INIT   = 4'(MUL_LAT);
  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_REQ - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_hit;
  logic [NUM_REQ-1:0] grant;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic               zero_hit;
  logic [31:0]        mul_a_q;
  logic [31:0]        mul_b_q;
  logic [31:0]        res_y_q;
  logic [ID_W-1:0]    res_id_q;
  logic               res_valid_q;

  // Rotating priority: the search starts at the requester after last_grant.
  always_comb begin : rr_pick
    int idx;
    idx       = 0;
    grant_hit = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_hit && bus.req_valid[idx]) begin
        grant_hit = 1'b1;
        grant_id  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_hit) grant[grant_id] = 1'b1;
  end

  assign sel_a = bus.req_a[32*int'(grant_id) +: 32];
  assign sel_b = bus.req_b[32*int'(grant_id) +: 32];

`ifdef FP_MUL_ARB_ZERO_BYPASS_EN
  assign zero_hit = (sel_a[30:23] == 8'h00) || (sel_b[30:23] == 8'h00);
`else
  assign zero_hit = 1'b0;
`endif

  // Gated by rst so that no grant shows while the block is held in reset.
  assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= LAST_RESET;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_y_q     <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_hit) begin
            last_grant <= grant_id;
            res_id_q   <= grant_id;
            if (zero_hit) begin
              res_y_q     <= {sel_a[31] ^ sel_b[31], 31'b0};
              res_valid_q <= 1'b1;
              state       <= HOLD;
            end else begin
              mul_a_q <= sel_a;
              mul_b_q <= sel_b;
              cnt     <= LAT_INIT;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            res_y_q     <= bus.mul_y;
            res_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.res_y     = res_y_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_valid = res_valid_q;
  assign busy          = (state != IDLE);
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one single-precision fp_mul datapath among NUM_REQ requesters.
- Each requester presents an operand pair (a, b) with a valid/ready handshake. The arbiter grants round-robin, drives the multiplier operands, and waits a fixed MUL_LAT cycles.
- It then returns the 32-bit product tagged with the requester index on a single valid/ready result port.
- Sits between client pipelines (e.g. dot-product or scaling units) and the multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of requester index; must satisfy 2**ID_W >= NUM_REQ.
- MUL_LAT, 2, cycles from mul_a/mul_b stable until mul_y is valid (min 1, max 15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  32*NUM_REQ  operand a, requester i at bits [32*i+31:32*i].
- req_b  in  32*NUM_REQ  operand b, same packing.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accept.
- res_y  out  32  IEEE 754 single-precision product.
- res_id  out  ID_W  index of the requester that owns res_y.
- mul_a  out  32  operand a to multiplier (registered).
- mul_b  out  32  operand b to multiplier (registered).
- mul_y  in  32  multiplier result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; res_valid=0; res_y=0; res_id=0; mul_a=0; mul_b=0; req_ready=0.
  - Counter=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, RUN, HOLD.
- IDLE:
  - req_ready is combinational: a one-hot grant g = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, ... wrapping modulo NUM_REQ.
  - req_ready is 0 in all other states.
  - Transfer on req_valid[g] & req_ready[g] (cycle T). At the T edge:
    - mul_a<=req_a[g]; mul_b<=req_b[g]; res_id<=g; last_grant<=g; cnt<=MUL_LAT; go to RUN.
  - No request pending: stay in IDLE; mul_a/mul_b hold their last values.
- RUN:
  - cnt decrements by 1 each cycle.
  - On the edge where cnt==1: res_y<=mul_y; res_valid<=1; go to HOLD.
  - res_valid therefore first rises at cycle T+MUL_LAT+1 after the accept cycle T.
- HOLD:
  - res_valid=1; res_y and res_id stable until res_valid & res_ready.
  - On that edge: res_valid<=0; go to IDLE.
  - No new accept in the same cycle as the result handshake. Minimum initiation interval is MUL_LAT+2 cycles.
- mul_a/mul_b remain constant throughout RUN and HOLD. The multiplier operands never change mid-operation.
- Requester obligations: hold req_valid and operands stable until accepted. Deasserting req_valid before the grant is legal; the arbiter samples requests only in IDLE.
- Fairness:
  - A continuously requesting requester waits at most NUM_REQ-1 other transactions.
  - Simultaneous requests are served in rotating order from last_grant+1.
- res_ready held low indefinitely: the block stays in HOLD; all req_ready=0; no operand change.
- Reset asserted mid-RUN or mid-HOLD: the in-flight transaction is dropped, with no result delivered. All outputs return to reset values immediately (asynchronously).
- Sign/exponent/mantissa are not interpreted except under the optional feature; arithmetic is entirely in the multiplier.

Optional Feature:
- Macro FP_MUL_ARB_ZERO_BYPASS_EN.
- When defined:
  - In IDLE, on accept, if either granted operand has exponent field 8'h00, the multiplier is bypassed.
  - res_y<={a[31]^b[31],31'b0}; res_valid<=1; state<=HOLD at the accept edge. res_valid rises at T+1.
  - mul_a/mul_b are not updated; last_grant and res_id update normally.
- When undefined: all operands go through the multiplier with MUL_LAT timing.
- In both cases the handshake rules are identical.

Test Plan:
- Single op: NUM_REQ=4, MUL_LAT=2, req_valid=4'b0001, a=32'h40000000, b=32'h40400000, model mul_y=32'h40C00000 -> req_ready[0] at T, res_valid at T+3, res_y=32'h40C00000, res_id=0.
- All four requesters valid from reset with res_ready=1 -> grant order 0,1,2,3, then 0 again; each accept spaced 4 cycles apart; res_id sequence 0,1,2,3.
- After a grant to 1, requesters 0 and 2 valid -> 2 granted before 0.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_y/res_id constant, req_ready=0, busy=1; release -> handshake, IDLE next cycle, new accept the cycle after.
- Reset mid-RUN (one cycle after accept) -> res_valid stays 0, mul_a=0, busy=0; requester 0 granted first on the next request.
- FP_MUL_ARB_ZERO_BYPASS_EN defined: a=32'h00000000, b=32'hC0000000 -> res_y=32'h80000000 at T+1, mul_a unchanged; undefined -> the same operands take the MUL_LAT path.
